os_drain_ctrl: RTL and testbench
================================

OS_DRAIN_CTRL -- requirements
Module: os_drain_ctrl

Interface
REQ-001 Parameters SHALL be: ROWS, default 4, PE rows per column chain; COLS, default 4, column chains; ACC_WIDTH, default 24, PE accumulator width; OUT_WIDTH, default 16, output element width, OUT_WIDTH <= ACC_WIDTH.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  single-cycle request to drain the array's accumulators.
REQ-005 load_en  output  1  broadcast to all PEs; copies each accumulator into its shift register.
REQ-006 shift_en  output  1  broadcast to all PEs; advances each column shift chain by one row.
REQ-007 col_dat  input  COLS*ACC_WIDTH  bottom-PE shift outputs; column c occupies bits [c*ACC_WIDTH +: ACC_WIDTH].
REQ-008 out_valid  output  1  out_data holds one result row.
REQ-009 out_ready  input  1  downstream accepts the row.
REQ-010 out_data  output  COLS*OUT_WIDTH  saturated result row; column c occupies [c*OUT_WIDTH +: OUT_WIDTH].
REQ-011 out_row_idx  output  $clog2(ROWS)  array row index of out_data.
REQ-012 out_last  output  1  out_data is the final row of the drain (row 0).
REQ-013 busy  output  1  drain in progress (state not IDLE).
REQ-014 done  output  1  single-cycle pulse in the cycle the last row is accepted.

Function
REQ-015 The FSM SHALL have states IDLE, LOAD and OUT.
REQ-016 IDLE: start=1 -> LOAD and row counter cnt cleared to 0; start=0 -> remain in IDLE.
REQ-017 LOAD: load_en=1 for exactly one cycle, then unconditionally -> OUT.
REQ-018 OUT: out_valid=1; a transfer occurs when out_valid & out_ready.
REQ-019 On a transfer with cnt<ROWS-1: shift_en=1 combinationally in that cycle, cnt increments, state remains OUT.
REQ-020 On a transfer with cnt==ROWS-1: shift_en=0, done=1, next state IDLE.
REQ-021 OUT with out_ready=0: state, cnt and all outputs SHALL hold; shift_en=0.
REQ-022 out_row_idx SHALL equal ROWS-1-cnt, giving bottom row first; out_last SHALL equal (state==OUT && cnt==ROWS-1).
REQ-023 out_data SHALL be a combinational function of col_dat: per column, value > 2^OUT_WIDTH-1 becomes 2^OUT_WIDTH-1, otherwise the low OUT_WIDTH bits; all values are unsigned.
REQ-024 Latency: start accepted at cycle t -> load_en at t+1 -> first out_valid at t+2; throughput is one row per cycle while out_ready=1.
REQ-025 load_en and shift_en SHALL never be asserted in the same cycle.
REQ-026 start while busy=1 SHALL be ignored and not queued; start in the cycle done=1 is also ignored.
REQ-027 out_valid SHALL not deassert without a transfer, and out_data SHALL stay stable while out_valid=1 and out_ready=0.

Reset
REQ-028 On rst_n low the block SHALL enter IDLE with cnt=0, and load_en, shift_en, out_valid, out_last, busy and done all 0; this applies mid-drain with no partial row output.
REQ-029 After reset release, the first start SHALL begin a complete drain from row ROWS-1.

Structure
REQ-030 The FSM state enum SHALL live in the shared systolic-array package, alongside the default ACC_WIDTH and OUT_WIDTH constants.
REQ-031 The per-column saturation SHALL be one sub-module, os_drain_sat (ACC_WIDTH in, OUT_WIDTH out), instantiated COLS times by generate.

Verification
REQ-032 ROWS=4, COLS=4, ACC=24, OUT=16, PE model loaded with acc[r][c]=16*r+c, out_ready=1, start pulse -> load_en at t+1; rows 3,2,1,0 on t+2..t+5; row 3 col 2 = 50; out_last and done at t+5; shift_en on exactly 3 cycles.
REQ-033 Same setup, out_ready toggled 1,0,0,1,... -> no row lost or duplicated; out_data and out_row_idx stable during stalls; shift_en only on transfer cycles.
REQ-034 acc[3][0]=0x012345 and acc[3][1]=0x00FFFF -> first row: col 0 = 0xFFFF (saturated), col 1 = 0xFFFF (exact).
REQ-035 start re-pulsed at t+3 and in the done cycle -> ignored; exactly 4 rows emitted; busy falls at t+6.
REQ-036 rst_n asserted at t+3 mid-drain -> all outputs 0 immediately; a following start yields a full 4-row drain beginning at row index 3.

Source files
------------

// File: rtl/os_drain_ctrl_pkg.sv
// Shared systolic-array definitions: drain FSM states and default datapath widths.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package os_drain_ctrl_pkg;

    // Default PE accumulator width and drained output element width.
    localparam int ACC_WIDTH_DEF = 24;
    localparam int OUT_WIDTH_DEF = 16;

    // Drain sequencer states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        OUT  = 2'd2
    } drain_state_t;

endpackage

// File: rtl/os_drain_sat.sv
// Unsigned saturation of one accumulator down to the output element width.
// Latency: combinational.
// Backpressure: none (pure function of acc_dat).
//
// Ports:
//   acc_dat  ACC_WIDTH  unsigned accumulator value
//   sat_dat  OUT_WIDTH  all-ones when acc_dat exceeds the output range, else its low bits
module os_drain_sat #(
    parameter int ACC_WIDTH = 24,
    parameter int OUT_WIDTH = 16
) (
    input  logic [ACC_WIDTH-1:0] acc_dat,
    output logic [OUT_WIDTH-1:0] sat_dat
);

    generate
        if (ACC_WIDTH > OUT_WIDTH) begin : g_sat
            // Any set bit above the output range means the value does not fit.
            assign sat_dat = (|acc_dat[ACC_WIDTH-1:OUT_WIDTH]) ? {OUT_WIDTH{1'b1}}
                                                                : acc_dat[OUT_WIDTH-1:0];
        end else begin : g_pass
            assign sat_dat = acc_dat[OUT_WIDTH-1:0];
        end
    endgenerate

endmodule

// File: rtl/os_drain_ctrl.sv
// Drains an output-stationary array: loads PE shift registers, then streams rows bottom-first.
// Latency: start at t -> load_en at t+1 -> first row valid at t+2; one row/cycle when ready.
// Backpressure: out_ready low holds state, row counter and row outputs; shift chain is not advanced.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   start                 single-cycle drain request (ignored while busy)
//   load_en, shift_en     broadcast PE controls: capture accumulators / advance column chains
//   col_dat               bottom-PE shift outputs, COLS x ACC_WIDTH
//   out_valid/out_ready   row handshake; out_data is the saturated row, out_row_idx its array row
//   out_last, done        final row flag; pulse in the cycle the final row is accepted
//   busy                  drain in progress
module os_drain_ctrl
    import os_drain_ctrl_pkg::*;
#(
    parameter int ROWS      = 4,
    parameter int COLS      = 4,
    parameter int ACC_WIDTH = ACC_WIDTH_DEF,
    parameter int OUT_WIDTH = OUT_WIDTH_DEF
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    output logic                      load_en,
    output logic                      shift_en,
    input  logic [COLS*ACC_WIDTH-1:0] col_dat,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [COLS*OUT_WIDTH-1:0] out_data,
    output logic [$clog2(ROWS)-1:0]   out_row_idx,
    output logic                      out_last,
    output logic                      busy,
    output logic                      done
);

    localparam int            CW   = $clog2(ROWS);
    localparam logic [CW-1:0] LAST = CW'(ROWS - 1);

    drain_state_t  state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          load_en_q, load_en_d;
    logic          out_valid_q, out_valid_d;
    logic          out_last_q, out_last_d;
    logic          busy_q, busy_d;
    logic          xfer;
    logic          is_last;

    assign xfer    = out_valid_q & out_ready;
    assign is_last = (cnt_q == LAST);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = LOAD;
                    cnt_d   = '0;
                end
            end
            LOAD: state_d = OUT;
            OUT: begin
                if (xfer) begin
                    if (is_last) state_d = IDLE;
                    else         cnt_d   = cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // Status outputs are registered: decode them from the next state.
        load_en_d   = (state_d == LOAD);
        out_valid_d = (state_d == OUT);
        out_last_d  = (state_d == OUT) && (cnt_d == LAST);
        busy_d      = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            load_en_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            load_en_q   <= load_en_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            busy_q      <= busy_d;
        end
    end

    assign load_en     = load_en_q;
    assign out_valid   = out_valid_q;
    assign out_last    = out_last_q;
    assign busy        = busy_q;
    // The chain only advances when a non-final row is consumed; after row 0 there is nothing left.
    assign shift_en    = xfer & ~is_last;
    assign done        = xfer & is_last;
    // Bottom row reaches col_dat first, so row index counts down.
    assign out_row_idx = LAST - cnt_q;

    generate
        for (genvar c = 0; c < COLS; c++) begin : g_col
            os_drain_sat #(
                .ACC_WIDTH (ACC_WIDTH),
                .OUT_WIDTH (OUT_WIDTH)
            ) u_sat (
                .acc_dat (col_dat[c*ACC_WIDTH +: ACC_WIDTH]),
                .sat_dat (out_data[c*OUT_WIDTH +: OUT_WIDTH])
            );
        end
    endgenerate

endmodule

// File: tb/tb_os_drain_ctrl.sv
// Directed bench for os_drain_ctrl with a 4x4 PE shift-chain model.
// Latency: not applicable.
// Backpressure: out_ready driven from per-test patterns.
module tb_os_drain_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        load_en;
    logic        shift_en;
    logic [95:0] col_dat;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic [1:0]  out_row_idx;
    logic        out_last;
    logic        busy;
    logic        done;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [63:0] first_row;

    logic [23:0] acc_tb [4][4];
    logic [23:0] sreg   [4][4];

    always #5 clk = ~clk;

    os_drain_ctrl #(
        .ROWS (4), .COLS (4), .ACC_WIDTH (24), .OUT_WIDTH (16)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .load_en     (load_en),
        .shift_en    (shift_en),
        .col_dat     (col_dat),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_row_idx (out_row_idx),
        .out_last    (out_last),
        .busy        (busy),
        .done        (done)
    );

    // PE column chains: row 3 is the bottom PE feeding col_dat.
    always @(posedge clk) begin
        if (load_en) begin
            sreg <= acc_tb;
        end else if (shift_en) begin
            for (int r = 3; r > 0; r--) sreg[r] <= sreg[r-1];
            for (int c = 0; c < 4; c++) sreg[0][c] <= 24'd0;
        end
    end

    always_comb begin
        col_dat = '0;
        for (int c = 0; c < 4; c++) col_dat[c*24 +: 24] = sreg[3][c];
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] sat16(input logic [23:0] v);
        return (v > 24'd65535) ? 16'hFFFF : v[15:0];
    endfunction

    function automatic logic [63:0] exp_row(input int r);
        logic [63:0] v;
        for (int c = 0; c < 4; c++) v[c*16 +: 16] = sat16(acc_tb[r][c]);
        return v;
    endfunction

    task automatic fill_acc();
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                acc_tb[r][c] = 24'(16 * r + c);
    endtask

    // One complete drain. mode 0: always ready; mode 1: ready pattern 1,0,0 from the first OUT cycle.
    // restart: re-pulse start at t+3 and in the out_last cycle.
    task automatic drain(input int mode, input bit restart, input string nm);
        int          rows, er, shifts, fall, done_k;
        bit          stalled;
        logic [63:0] prev_dat;
        logic [1:0]  prev_idx;
        rows = 0; er = 3; shifts = 0; fall = -1; done_k = -1; stalled = 0;
        prev_dat = '0; prev_idx = '0;
        start = 1'b1; out_ready = 1'b1;
        #1;
        chk({nm, ":busy_t0"}, 64'(busy), 64'd0);
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 1; k < 40 && fall < 0; k++) begin
            out_ready = (mode == 0) ? 1'b1 : ((k % 3) == 2);
            #1;
            if (k == 1) begin
                chk({nm, ":load_t1"}, 64'(load_en), 64'd1);
                chk({nm, ":vld_t1"}, 64'(out_valid), 64'd0);
            end
            chk({nm, ":excl"}, 64'(load_en & shift_en), 64'd0);
            chk({nm, ":shift"}, 64'(shift_en), 64'(out_valid & out_ready & (er > 0)));
            if (stalled) begin
                chk({nm, ":stall_vld"}, 64'(out_valid), 64'd1);
                chk({nm, ":stall_dat"}, out_data, prev_dat);
                chk({nm, ":stall_idx"}, 64'(out_row_idx), 64'(prev_idx));
            end
            if (out_valid && out_ready) begin
                chk({nm, ":idx"}, 64'(out_row_idx), 64'(er));
                chk({nm, ":dat"}, out_data, exp_row(er));
                chk({nm, ":last"}, 64'(out_last), 64'(er == 0));
                chk({nm, ":done"}, 64'(done), 64'(er == 0));
                if (rows == 0) first_row = out_data;
                if (er == 0) done_k = k;
                rows++;
                er--;
            end else begin
                chk({nm, ":no_done"}, 64'(done), 64'd0);
            end
            if (shift_en) shifts++;
            stalled  = out_valid && !out_ready;
            prev_dat = out_data;
            prev_idx = out_row_idx;
            if (k > 1 && !busy) fall = k;
            start = restart && (k == 3 || out_last);
            @(posedge clk); #1;
        end
        start = 1'b0;
        chk({nm, ":timeout"}, 64'(fall > 0), 64'd1);
        chk({nm, ":rows"}, 64'(rows), 64'd4);
        chk({nm, ":shifts"}, 64'(shifts), 64'd3);
        if (mode == 0) begin
            chk({nm, ":done_cyc"}, 64'(done_k), 64'd5);
            chk({nm, ":busy_fall"}, 64'(fall), 64'd6);
        end
        // Nothing may follow: a queued start would raise load_en here.
        for (int i = 0; i < 3; i++) begin
            chk({nm, ":post_load"}, 64'(load_en), 64'd0);
            chk({nm, ":post_vld"}, 64'(out_valid), 64'd0);
            @(posedge clk); #1;
        end
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, ":load_en"}, 64'(load_en), 64'd0);
        chk({nm, ":shift_en"}, 64'(shift_en), 64'd0);
        chk({nm, ":out_valid"}, 64'(out_valid), 64'd0);
        chk({nm, ":out_last"}, 64'(out_last), 64'd0);
        chk({nm, ":busy"}, 64'(busy), 64'd0);
        chk({nm, ":done"}, 64'(done), 64'd0);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; out_ready = 1'b1;
        fill_acc();
        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset");
        chk("reset:row_idx", 64'(out_row_idx), 64'd3);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Basic drain, always ready; bottom row column 2 is 16*3+2.
        drain(0, 1'b0, "basic");
        chk("basic:r3c2", 64'(first_row[47:32]), 64'd50);

        // Backpressure pattern.
        drain(1, 1'b0, "stall");

        // Restart pulses while busy and in the done cycle are dropped.
        drain(0, 1'b1, "restart");

        // Saturation on the first row.
        acc_tb[3][0] = 24'h012345;
        acc_tb[3][1] = 24'h00FFFF;
        drain(0, 1'b0, "sat");
        chk("sat:c0", 64'(first_row[15:0]), 64'hFFFF);
        chk("sat:c1", 64'(first_row[31:16]), 64'hFFFF);
        chk("sat:c2", 64'(first_row[47:32]), 64'd50);
        fill_acc();

        // Mid-drain reset at t+3.
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("mid:vld_before", 64'(out_valid), 64'd1);
        rst_n = 1'b0;
        #1;
        chk_all_zero("mid_rst");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        drain(0, 1'b0, "post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
